axi_ooo_rd_slave: RTL and testbench
===================================

# axi_ooo_rd_slave

Parametrised AXI read-slave responder that sits on the fabric side of the ROB, on the ROB's AR-out / R-in channels. It accepts up to DEPTH outstanding read requests and returns their bursts in a selectable order: in-order, reverse, or pseudo-random. Data is generated deterministically from the address, so ROB reordering can be verified both in the bench and on FPGA without a memory model. It replaces hand-driven single-beat and burst responses with a synthesisable, configurable out-of-order source.

## Interface
- ID_WIDTH, 4, width of AR/R id (ROB UID)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, R data width; must be ≥ ADDR_WIDTH
- LEN_WIDTH, 8, AR len width (beats = len+1)
- RESP_WIDTH, 2, R resp width
- DEPTH, 8, outstanding request slots (power of 2, ≥2)
- MODE, 0, 0 = oldest-first, 1 = youngest-first, 2 = LFSR-random
- LFSR_SEED, 16'hACE1, 16-bit LFSR reset value; must be non-zero
- ERR_ADDR_BIT, ADDR_WIDTH-1, address bit that forces SLVERR on all beats of a request
---
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ar_valid  in  1  request valid
- ar_ready  out  1  slot available
- ar_id  in  ID_WIDTH  request UID
- ar_addr  in  ADDR_WIDTH  start address
- ar_len  in  LEN_WIDTH  beats-1
- ar_size  in  3  bytes/beat = 1<<size
- ar_burst  in  2  00 FIXED, 01 INCR; other codes are treated as INCR
- r_valid  out  1  beat valid
- r_ready  in  1  beat accepted
- r_id  out  ID_WIDTH  UID of the request
- r_data  out  DATA_WIDTH  zero-extended beat address
- r_resp  out  RESP_WIDTH  2'b00 OKAY, 2'b10 SLVERR
- r_last  out  1  final beat of the burst

## Operation
- Slot table: DEPTH entries, each holding valid, id, addr, len, size, burst, beat counter (LEN_WIDTH), age (clog2(DEPTH) bits).
- Accept:
  - ar_valid & ar_ready writes the lowest-index free slot.
  - The new slot gets age 0; every other valid slot's age increments, saturating.
- Eligibility: a slot is valid and no older valid slot has the same id. This preserves AXI same-ID ordering in every MODE.
- Selection among eligible slots:
  - MODE 0: maximum age.
  - MODE 1: minimum age.
  - MODE 2: scan upward, wrapping, from index lfsr[clog2(DEPTH)-1:0] to the first eligible slot.
  - The LFSR (x^16+x^14+x^13+x^11) advances every cycle.
- FSM:
  - IDLE: if any slot is eligible, register the selected slot index and go to BURST; otherwise stay in IDLE.
  - BURST: drive the beat; on r_valid & r_ready, increment the beat counter.
  - On the last-beat handshake: free the slot and go to IDLE.
- Beat address:
  - FIXED: addr.
  - INCR: addr + (beat << size), width ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH.
- Outputs: r_data = zero-extended beat address; r_last = (beat == len); r_resp = addr[ERR_ADDR_BIT] ? 2'b10 : 2'b00.

## Timing
- Reset values: ar_ready 0, r_valid 0, r_id 0, r_data 0, r_resp 0, r_last 0; all slots invalid; FSM in IDLE; LFSR = LFSR_SEED.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronous) and all outstanding requests are dropped.
- ar_ready = !full, from registered state. A slot freed in cycle T raises ar_ready in T+1, never in T.
- Latency: AR handshake at edge T → slot selectable in T+1 → r_valid high in T+2 (minimum).
- Beats are back-to-back while r_ready is held high.
- After r_last, the next burst's r_valid comes ≥1 cycle later (IDLE cycle).
- While r_valid is high and r_ready is low, r_id/r_data/r_resp/r_last stay stable.
- Accept and last-beat retire in the same cycle: both take effect. Age increments apply only to slots still valid after the retire.
- Full (DEPTH valid slots): ar_ready 0. Empty: FSM stays in IDLE, r_valid 0.

## Configuration
- AXI_SLV_INTERLEAVE_EN defined:
  - After each non-last beat handshake, the FSM returns to selection, starting from the current slot index + 1, round-robin.
  - It switches to another eligible slot with a different id if one exists; otherwise it continues the current burst.
  - Beats of different UIDs therefore interleave.
- Undefined: bursts are atomic; the FSM leaves BURST only after r_last.

## Test plan
- MODE 0, one request id=0 addr=0x1000 len=0 → one beat id=0 data=0x1000 resp=00 last=1, r_valid exactly 2 cycles after the AR handshake.
- MODE 1, two requests (id=1 addr=0x2000, id=2 addr=0x3000), both len=0 → beat for id=2 first, then id=1.
- MODE 0, id=5 addr=0x4000 len=3 size=3 INCR, with r_ready toggling every other cycle → data 0x4000, 0x4008, 0x4010, 0x4018; last only on beat 4; outputs stable while stalled.
- DEPTH=8: issue 9 requests with r_ready=0 → ar_ready drops after 8. Release r_ready → ar_ready returns the cycle after the first retire, and the 9th request is accepted.
- MODE 2 with two requests of the same id=7 plus one of id=8 → id=7 beats stay in issue order. Request with addr=0x8000_0000 → resp=2'b10 on every beat.
- Interleave enabled: id=1 len=1 and id=2 len=1 → r_id sequence 1, 2, 1, 2; disabled → 1, 1, 2, 2. Asserting rst mid-burst → r_valid drops immediately and nothing is returned after reset.

Source files
------------

// File: rtl/axi_ooo_rd_slave.sv
// AXI read-slave responder returning bursts in-order, reversed or LFSR-random.
// Define AXI_SLV_INTERLEAVE_EN to interleave beats of different ids.
module axi_ooo_rd_slave #(
    parameter int          ID_WIDTH     = 4,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 64,
    parameter int          LEN_WIDTH    = 8,
    parameter int          RESP_WIDTH   = 2,
    parameter int          DEPTH        = 8,
    parameter int          MODE         = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          ERR_ADDR_BIT = ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [LEN_WIDTH-1:0]  ar_len,
    input  logic [2:0]            ar_size,
    input  logic [1:0]            ar_burst,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [RESP_WIDTH-1:0] r_resp,
    output logic                  r_last
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    logic [DEPTH-1:0]      vld;
    logic [DEPTH-1:0]      vld_nxt;
    logic [DEPTH-1:0]      elig;
    logic [ID_WIDTH-1:0]   s_id    [DEPTH];
    logic [ADDR_WIDTH-1:0] s_addr  [DEPTH];
    logic [LEN_WIDTH-1:0]  s_len   [DEPTH];
    logic [LEN_WIDTH-1:0]  s_cnt   [DEPTH];
    logic [2:0]            s_size  [DEPTH];
    logic [1:0]            s_burst [DEPTH];
    logic [IW-1:0]         s_age   [DEPTH];
    logic [IW-1:0]         age_nxt [DEPTH];

    state_t        state;
    logic [IW-1:0] cur;
    logic [15:0]   lfsr;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] sel_idx;
    logic          sel_any;
    logic          accept;
    logic          hs;
    logic          last_hs;
    logic [IW-1:0] nxt_idx;
    logic [LEN_WIDTH-1:0]  nxt_beat;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0]  b,
        input logic [2:0]            sz,
        input logic [1:0]            bu
    );
        if (bu == 2'b00)
            return a;
        return a + (ADDR_WIDTH'(b) << sz);
    endfunction

    assign accept  = ar_valid & ar_ready;
    assign hs      = r_valid & r_ready;
    assign last_hs = hs & r_last;

    // Oldest slot of each id is the only one allowed to respond
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = vld[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && vld[j] && s_id[j] == s_id[i] &&
                    s_age[j] > s_age[i])
                    elig[i] = 1'b0;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!vld[i])
                free_idx = IW'(i);
    end

    always_comb begin
        logic [IW-1:0] scan;
        logic [IW-1:0] best;
        logic          fnd;
        scan    = '0;
        best    = '0;
        fnd     = 1'b0;
        sel_idx = '0;
        sel_any = |elig;
        if (MODE == 2) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                scan = lfsr[IW-1:0] + IW'(k);
                if (elig[scan])
                    sel_idx = scan;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (elig[i] && (!fnd ||
                    (MODE == 1 ? s_age[i] < best : s_age[i] > best))) begin
                    fnd     = 1'b1;
                    best    = s_age[i];
                    sel_idx = IW'(i);
                end
        end
    end

`ifdef AXI_SLV_INTERLEAVE_EN
    logic [IW-1:0] sw_idx;
    logic          sw_any;

    always_comb begin
        logic [IW-1:0] scan;
        scan   = '0;
        sw_idx = cur;
        sw_any = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            scan = cur + IW'(k);
            if (elig[scan] && s_id[scan] != s_id[cur]) begin
                sw_idx = scan;
                sw_any = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        nxt_idx  = cur;
        nxt_beat = s_cnt[cur];
        if (hs) begin
            nxt_beat = s_cnt[cur] + 1'b1;
`ifdef AXI_SLV_INTERLEAVE_EN
            if (sw_any) begin
                nxt_idx  = sw_idx;
                nxt_beat = s_cnt[sw_idx];
            end
`endif
        end
        nxt_addr = beat_addr(s_addr[nxt_idx], nxt_beat,
                             s_size[nxt_idx], s_burst[nxt_idx]);
    end

    // Ages form a dense rank (count of younger slots), so they never tie
    always_comb begin
        vld_nxt = vld;
        if (last_hs)
            vld_nxt[cur] = 1'b0;
        if (accept)
            vld_nxt[free_idx] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            age_nxt[i] = s_age[i];
            if (last_hs && s_age[i] > s_age[cur])
                age_nxt[i] = age_nxt[i] - IW'(1);
            if (accept && age_nxt[i] != IW'(DEPTH - 1))
                age_nxt[i] = age_nxt[i] + IW'(1);
            if (accept && free_idx == IW'(i))
                age_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            lfsr     <= LFSR_SEED;
            vld      <= '0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_data   <= '0;
            r_resp   <= '0;
            r_last   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                s_id[i]    <= '0;
                s_addr[i]  <= '0;
                s_len[i]   <= '0;
                s_cnt[i]   <= '0;
                s_size[i]  <= '0;
                s_burst[i] <= '0;
                s_age[i]   <= '0;
            end
        end else begin
            lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            vld      <= vld_nxt;
            ar_ready <= ~&vld_nxt;
            for (int i = 0; i < DEPTH; i++)
                s_age[i] <= age_nxt[i];
            if (hs && !r_last)
                s_cnt[cur] <= s_cnt[cur] + 1'b1;
            if (accept) begin
                s_id[free_idx]    <= ar_id;
                s_addr[free_idx]  <= ar_addr;
                s_len[free_idx]   <= ar_len;
                s_cnt[free_idx]   <= '0;
                s_size[free_idx]  <= ar_size;
                s_burst[free_idx] <= ar_burst;
            end
            unique case (state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (sel_any) begin
                        cur   <= sel_idx;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (!r_valid || (hs && !r_last)) begin
                        cur     <= nxt_idx;
                        r_valid <= 1'b1;
                        r_id    <= s_id[nxt_idx];
                        r_data  <= DATA_WIDTH'(nxt_addr);
                        r_last  <= (nxt_beat == s_len[nxt_idx]);
                        r_resp  <= s_addr[nxt_idx][ERR_ADDR_BIT] ?
                                   RESP_WIDTH'(2) : '0;
                    end else if (hs) begin
                        r_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ooo_rd_slave.sv
// Scoreboard bench for axi_ooo_rd_slave: one instance per MODE, per-id
// expected-beat queues filled at issue and drained by a negedge monitor.
module tb_axi_ooo_rd_slave;
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ar_valid [3];
    logic        ar_ready [3];
    logic [3:0]  ar_id    [3];
    logic [31:0] ar_addr  [3];
    logic [7:0]  ar_len   [3];
    logic [2:0]  ar_size  [3];
    logic [1:0]  ar_burst [3];
    logic        r_valid  [3];
    logic        r_ready  [3];
    logic [3:0]  r_id     [3];
    logic [63:0] r_data   [3];
    logic [1:0]  r_resp   [3];
    logic        r_last   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_ooo_rd_slave #(.MODE(g)) u_dut (
            .clk(clk), .rst(rst),
            .ar_valid(ar_valid[g]), .ar_ready(ar_ready[g]),
            .ar_id(ar_id[g]), .ar_addr(ar_addr[g]), .ar_len(ar_len[g]),
            .ar_size(ar_size[g]), .ar_burst(ar_burst[g]),
            .r_valid(r_valid[g]), .r_ready(r_ready[g]), .r_id(r_id[g]),
            .r_data(r_data[g]), .r_resp(r_resp[g]), .r_last(r_last[g])
        );
    end

    int   nvec = 0;
    int   nerr = 0;
    int   act = 0;
    int   rdy_mode = 0;
    logic rdy_val = 1'b0;
    int   beats = 0;
    exp_t expq [16][$];
    int   beat_log [$];
    int   burst_log [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] a,
                       input logic [127:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic bad(input string name, input int a);
        nvec++;
        nerr++;
        $display("FAIL %s: got %0d", name, a);
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 16; i++)
            n += expq[i].size();
        return n;
    endfunction

    // Single writer of r_ready: hold, toggle or random per rdy_mode
    initial begin
        for (int i = 0; i < 3; i++)
            r_ready[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (i != act)
                    r_ready[i] = 1'b1;
                else if (rdy_mode == 1)
                    r_ready[i] = !r_ready[i];
                else if (rdy_mode == 2)
                    r_ready[i] = ($urandom_range(0, 3) != 0);
                else
                    r_ready[i] = rdy_val;
            end
        end
    end

    task automatic set_ready(input int mode, input logic v);
        @(negedge clk);
        rdy_mode = mode;
        rdy_val  = v;
        @(posedge clk);
        #2;
    endtask

    // Reference beats straight from the address rules
    task automatic push_exp(input int id, input logic [31:0] addr,
                            input int len, input int size, input int burst);
        exp_t e;
        logic [31:0] a;
        for (int b = 0; b <= len; b++) begin
            a = (burst == 0) ? addr : addr + 32'(b * (1 << size));
            e.data = {32'h0, a};
            e.resp = addr[31] ? 2'b10 : 2'b00;
            e.last = (b == len);
            expq[id].push_back(e);
        end
    endtask

    task automatic issue(input int id, input logic [31:0] addr,
                         input int len, input int size, input int burst);
        bit ok = 0;
        ar_id[act]    = 4'(id);
        ar_addr[act]  = addr;
        ar_len[act]   = 8'(len);
        ar_size[act]  = 3'(size);
        ar_burst[act] = 2'(burst);
        ar_valid[act] = 1'b1;
        for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (ar_ready[act]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            bad("ar_ready_timeout", id);
            ar_valid[act] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ar_valid[act] = 1'b0;
            push_exp(id, addr, len, size, burst);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (pending() == 0 && !r_valid[act])
                break;
        end
        chk("drain_pending", pending(), 0);
        repeat (5) @(negedge clk);
    endtask

    // Monitor: scoreboard pop, stall stability and burst atomicity
    logic        stall = 0;
    logic [70:0] held;
    logic        in_burst = 0;
    logic [3:0]  burst_id;
    always @(negedge clk) begin
        int   m;
        exp_t e;
        m = act;
        if (rst) begin
            stall    = 0;
            in_burst = 0;
        end else begin
            if (stall && r_valid[m])
                chk("stall_stable",
                    {r_id[m], r_data[m], r_resp[m], r_last[m]}, held);
            stall = r_valid[m] && !r_ready[m];
            held  = {r_id[m], r_data[m], r_resp[m], r_last[m]};
            if (r_valid[m] && r_ready[m]) begin
                beats++;
                beat_log.push_back(int'(r_id[m]));
                if (expq[r_id[m]].size() == 0) begin
                    bad("unexpected_beat_id", int'(r_id[m]));
                end else begin
                    e = expq[r_id[m]].pop_front();
                    chk("beat", {r_data[m], r_resp[m], r_last[m]}, e);
                end
`ifndef AXI_SLV_INTERLEAVE_EN
                if (in_burst)
                    chk("burst_atomic", r_id[m], burst_id);
`endif
                in_burst = !r_last[m];
                burst_id = r_id[m];
                if (r_last[m])
                    burst_log.push_back(int'(r_id[m]));
            end
        end
    end

    task automatic clear_logs();
        beat_log.delete();
        burst_log.delete();
    endtask

    task automatic chk_log(input string name, input int q[$],
                           input int e0, input int e1, input int e2,
                           input int e3, input int n);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_len"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++)
            chk(name, q[i], e[i]);
    endtask

    initial begin
        logic [31:0] a;
        int b0;
        bit seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ar_valid[i] = 0; ar_id[i] = 0; ar_addr[i] = 0;
            ar_len[i] = 0; ar_size[i] = 0; ar_burst[i] = 0;
        end
        #23;
        for (int i = 0; i < 3; i++)
            chk("reset_outputs",
                {ar_ready[i], r_valid[i], r_id[i], r_data[i],
                 r_resp[i], r_last[i]}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("ar_ready_after_reset", ar_ready[i], 1'b1);

        // Single beat latency, MODE 0
        act = 0;
        set_ready(0, 1'b1);
        issue(0, 32'h1000, 0, 0, 1);
        @(negedge clk); chk("latency_c0", r_valid[0], 1'b0);
        @(negedge clk); chk("latency_c1", r_valid[0], 1'b0);
        @(negedge clk); chk("latency_c2", r_valid[0], 1'b1);
        drain();

        // Oldest-first vs youngest-first behind a stalled blocker
        for (int m = 0; m < 2; m++) begin
            act = m;
            clear_logs();
            set_ready(0, 1'b0);
            issue(3, 32'h1100, 0, 0, 1);
            issue(1, 32'h2000, 0, 0, 1);
            issue(2, 32'h3000, 0, 0, 1);
            set_ready(0, 1'b1);
            drain();
            if (m == 0)
                chk_log("order_mode0", burst_log, 3, 1, 2, 0, 3);
            else
                chk_log("order_mode1", burst_log, 3, 2, 1, 0, 3);
        end

        // INCR burst with r_ready toggling
        act = 0;
        clear_logs();
        set_ready(1, 1'b0);
        issue(5, 32'h4000, 3, 3, 1);
        drain();
        chk("toggle_beats", beat_log.size(), 4);

        // Full table: 9th request waits for the first retire
        set_ready(0, 1'b0);
        for (int i = 0; i < 8; i++)
            issue(i, 32'h100 * i, 0, 0, 1);
        @(negedge clk);
        chk("full_ar_ready", ar_ready[0], 1'b0);
        ar_id[0] = 4'd8; ar_addr[0] = 32'h5000; ar_len[0] = 0;
        ar_size[0] = 0; ar_burst[0] = 1; ar_valid[0] = 1'b1;
        push_exp(8, 32'h5000, 0, 0, 1);
        set_ready(0, 1'b1);
        @(negedge clk);
        chk("full_pre_retire", {r_valid[0], ar_ready[0]}, 2'b10);
        @(negedge clk);
        chk("ready_after_retire", ar_ready[0], 1'b1);
        @(posedge clk);
        #1;
        ar_valid[0] = 1'b0;
        drain();

        // Random order: same-id order and SLVERR on every beat
        act = 2;
        set_ready(0, 1'b0);
        issue(9, 32'h0900, 0, 0, 1);
        issue(7, 32'h0500, 1, 2, 1);
        issue(7, 32'h0600, 1, 2, 1);
        issue(8, 32'h8000_0000, 2, 2, 1);
        set_ready(2, 1'b0);
        drain();

        // Interleave
        act = 0;
        clear_logs();
        set_ready(0, 1'b1);
        issue(1, 32'h7000, 1, 2, 1);
        issue(2, 32'h7100, 1, 2, 1);
        drain();
`ifdef AXI_SLV_INTERLEAVE_EN
        chk_log("interleave", beat_log, 1, 2, 1, 2, 4);
`else
        chk_log("interleave", beat_log, 1, 1, 2, 2, 4);
`endif

        // Randomised traffic on every mode
        for (int m = 0; m < 3; m++) begin
            act = m;
            set_ready(2, 1'b0);
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 3))
                    0: a = $urandom;
                    1: a = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    2: a = 32'h8000_0000 | ($urandom & 32'hFFFF);
                    default: a = $urandom & 32'hFFFF;
                endcase
                issue($urandom_range(0, 3), a, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            drain();
        end

        // Reset in the middle of a burst
        act = 0;
        set_ready(0, 1'b0);
        issue(4, 32'h9000, 3, 2, 1);
        issue(6, 32'h9100, 0, 0, 1);
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (r_valid[0]) begin
                seen = 1;
                break;
            end
        end
        chk("pre_reset_valid", seen, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async", {r_valid[0], ar_ready[0], r_data[0]}, '0);
        for (int i = 0; i < 16; i++)
            expq[i].delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_ready(0, 1'b1);
        b0 = beats;
        repeat (30) @(negedge clk);
        chk("post_reset_beats", beats - b0, 0);
        chk("post_reset_ready", ar_ready[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
